// File: rtl/serial_arith_pkg.sv
// Shared types and sizing helpers for the digit-serial arithmetic blocks.
package serial_arith_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      IN_WORD = 1'b1
   } state_t;

   // Digit counter width; never below one bit so the counter always exists.
   function automatic int unsigned cnt_width(input int unsigned word_digits);
      return (word_digits < 2) ? 1 : $clog2(word_digits);
   endfunction

endpackage

// File: rtl/digit_full_adder.sv
// DIGIT_W-wide ripple of gate-level full adders; exposes the MSB carry-in for overflow.
module digit_full_adder #(
   parameter int unsigned DIGIT_W = 1
) (
   input  logic [DIGIT_W-1:0] i_a,
   input  logic [DIGIT_W-1:0] i_b,
   input  logic               i_c,
   output logic [DIGIT_W-1:0] o_sum,
   output logic               o_carry,
   output logic               o_msb_cin
);

   logic [DIGIT_W:0] w_c;

   assign w_c[0] = i_c;

   for (genvar g = 0; g < DIGIT_W; g++) begin : g_fa
      logic w_p;
      assign w_p        = i_a[g] ^ i_b[g];
      assign o_sum[g]   = w_p ^ w_c[g];
      assign w_c[g+1]   = (i_a[g] & i_b[g]) | (w_c[g] & w_p);
   end

   assign o_carry   = w_c[DIGIT_W];
   assign o_msb_cin = w_c[DIGIT_W-1];

endmodule

// File: rtl/serial_add_sub_digit.sv
// Digit-serial adder/subtractor: LSB digit first, framed words, per-word mode,
// stall/restart handling and final carry/overflow flags, one cycle latency.
module serial_add_sub_digit
   import serial_arith_pkg::*;
#(
   parameter int unsigned DIGIT_W     = 1,
   parameter int unsigned WORD_DIGITS = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic               in_first,
   input  logic               in_sub,
   input  logic [DIGIT_W-1:0] in_a,
   input  logic [DIGIT_W-1:0] in_b,
   output logic               out_valid,
   output logic [DIGIT_W-1:0] out_digit,
   output logic               out_last,
   output logic               out_carry,
   output logic               out_overflow
);

   localparam int unsigned      CNT_W    = cnt_width(WORD_DIGITS);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_DIGITS - 1);

   if (WORD_DIGITS < 2) begin : g_bad_word_digits
      $error("serial_add_sub_digit: WORD_DIGITS must be at least 2");
   end
   if (DIGIT_W < 1) begin : g_bad_digit_w
      $error("serial_add_sub_digit: DIGIT_W must be at least 1");
   end

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_carry;
   logic               r_mode;

   logic               r_out_valid;
   logic [DIGIT_W-1:0] r_out_digit;
   logic               r_out_last;
   logic               r_out_carry;
   logic               r_out_overflow;

   logic               w_start;
   logic               w_accept;
   logic               w_mode;
   logic               w_cin;
   logic [DIGIT_W-1:0] w_b_eff;
   logic [CNT_W-1:0]   w_cnt_eff;
   logic               w_last;
   logic [DIGIT_W-1:0] w_sum;
   logic               w_cout;
   logic               w_msb_cin;

   // A first digit always starts a fresh word, reseeding mode, carry and index.
   always_comb begin
      w_start   = in_valid & in_first;
      w_accept  = in_valid & ((r_state == IN_WORD) | in_first);
      w_mode    = w_start ? in_sub : r_mode;
      w_cin     = w_start ? in_sub : r_carry;
      w_b_eff   = w_mode ? ~in_b : in_b;
      w_cnt_eff = w_start ? '0 : r_cnt;
      w_last    = (w_cnt_eff == LAST_IDX);
   end

   digit_full_adder #(
      .DIGIT_W (DIGIT_W)
   ) u_fa (
      .i_a       (in_a),
      .i_b       (w_b_eff),
      .i_c       (w_cin),
      .o_sum     (w_sum),
      .o_carry   (w_cout),
      .o_msb_cin (w_msb_cin)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= IDLE;
         r_cnt          <= '0;
         r_carry        <= 1'b0;
         r_mode         <= 1'b0;
         r_out_valid    <= 1'b0;
         r_out_digit    <= '0;
         r_out_last     <= 1'b0;
         r_out_carry    <= 1'b0;
         r_out_overflow <= 1'b0;
      end else if (w_accept) begin
         r_out_valid    <= 1'b1;
         r_out_digit    <= w_sum;
         r_out_last     <= w_last;
         r_out_carry    <= w_last & w_cout;
         r_out_overflow <= w_last & (w_cout ^ w_msb_cin);
         r_carry        <= w_cout;
         r_mode         <= w_mode;
         if (w_last) begin
            r_state <= IDLE;
            r_cnt   <= '0;
         end else begin
            r_state <= IN_WORD;
            r_cnt   <= w_cnt_eff + CNT_W'(1);
         end
      end else begin
         // Stall or dropped digit: word state holds, output slot is empty.
         r_out_valid    <= 1'b0;
         r_out_digit    <= '0;
         r_out_last     <= 1'b0;
         r_out_carry    <= 1'b0;
         r_out_overflow <= 1'b0;
      end
   end

   assign out_valid    = r_out_valid;
   assign out_digit    = r_out_digit;
   assign out_last     = r_out_last;
   assign out_carry    = r_out_carry;
   assign out_overflow = r_out_overflow;

endmodule
